// File: rtl/gf2_ka_mult_seq.sv
// gf2_ka_mult_seq
// ---------------------------------------------------------------------------
// Digit-serial carry-less (GF(2)[x]) polynomial multiplier. Operand b is
// consumed DIGIT bits per cycle, most significant digit first. Each cycle one
// WIDTH x DIGIT carry-less partial product is folded into a shifted
// accumulator. NDIG = ceil(WIDTH/DIGIT) MUL cycles produce the full
// 2*WIDTH-1 bit product.
//
// Optional feature, macro GF2_MULT_REDUCE_EN:
//   defined   - an extra RED cycle reduces the product modulo x^WIDTH + POLY.
//               y[WIDTH-1:0] holds the field element and the upper bits are 0.
//   undefined - y is the full unreduced product and POLY is ignored.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   in_valid   operands a/b valid
//   in_ready   block is idle and can take operands
//   a, b       WIDTH-bit operand polynomials (bit i = coefficient of x^i)
//   out_valid  result on y is valid
//   out_ready  downstream accepts the result
//   y          2*WIDTH-1 bit result, held stable between results
// ---------------------------------------------------------------------------
module gf2_ka_mult_seq #(
    parameter int unsigned      WIDTH = 163,
    parameter int unsigned      DIGIT = 41,
    parameter logic [WIDTH-1:0] POLY  = WIDTH'(8'hC9)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-2:0]   y
);

    localparam int unsigned NDIG = (WIDTH + DIGIT - 1) / DIGIT;
    localparam int unsigned PW   = 2 * WIDTH - 1;
    localparam int unsigned BW   = NDIG * DIGIT;
    localparam int unsigned CW   = (NDIG > 1) ? $clog2(NDIG) : 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_MUL  = 2'd1;
`ifdef GF2_MULT_REDUCE_EN
    localparam logic [1:0] ST_RED  = 2'd2;
`endif
    localparam logic [1:0] ST_DONE = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [PW-1:0]    acc_q, acc_d;
    logic [PW-1:0]    y_q, y_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic [BW-1:0]    bExt;
    logic [DIGIT-1:0] digitCur;
    logic [PW-1:0]    accStep;

    // Carry-less product of the full multiplicand with one digit: every set
    // digit bit XORs in a shifted copy of x. The result never exceeds
    // WIDTH+DIGIT-1 bits, which fits in PW because DIGIT <= WIDTH.
    function automatic logic [PW-1:0] clmulDigit(input logic [WIDTH-1:0] x,
                                                 input logic [DIGIT-1:0] d);
        logic [PW-1:0] r;
        r = '0;
        for (int j = 0; j < int'(DIGIT); j++) begin
            if (d[j]) begin
                r = r ^ (PW'(x) << j);
            end
        end
        return r;
    endfunction

    // Reduction modulo x^WIDTH + POLY by folding the top bit down one
    // position at a time. Walking from the MSB downward guarantees that a
    // fold only disturbs bits below the one being cleared, so a single pass
    // leaves nothing at or above x^WIDTH.
    function automatic logic [PW-1:0] foldReduce(input logic [PW-1:0] p);
        logic [PW-1:0] r;
        r = p;
        for (int i = int'(PW) - 1; i >= int'(WIDTH); i--) begin
            if (r[i]) begin
                r = r ^ (PW'(POLY) << (i - int'(WIDTH))) ^ (PW'(1) << i);
            end
        end
        return r;
    endfunction

    // Select the digit of b addressed by the counter. b is zero-extended to
    // a whole number of digits so a short top digit contributes nothing.
    always_comb begin
        bExt = '0;
        bExt[WIDTH-1:0] = b_q;
        digitCur = '0;
        for (int k = 0; k < int'(NDIG); k++) begin
            if (cnt_q == CW'(k)) begin
                digitCur = bExt[k*DIGIT +: DIGIT];
            end
        end
        accStep = (acc_q << DIGIT) ^ clmulDigit(a_q, digitCur);
    end

    // Next-state logic: accept in IDLE, one digit per MUL cycle, optional
    // reduction cycle, then hold the result in DONE until it is taken.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        y_d     = y_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    acc_d   = '0;
                    cnt_d   = CW'(NDIG - 1);
                    state_d = ST_MUL;
                end
            end
            ST_MUL: begin
                acc_d = accStep;
                if (cnt_q == '0) begin
`ifdef GF2_MULT_REDUCE_EN
                    state_d = ST_RED;
`else
                    y_d     = accStep;
                    state_d = ST_DONE;
`endif
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
`ifdef GF2_MULT_REDUCE_EN
            ST_RED: begin
                y_d     = foldReduce(acc_q);
                state_d = ST_DONE;
            end
`endif
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers; reset discards any operation in flight.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            y_q     <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            y_q     <= y_d;
            cnt_q   <= cnt_d;
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign y         = y_q;

endmodule

// File: tb/tb_gf2_ka_mult_seq.sv
// tb_gf2_ka_mult_seq
// Bench for gf2_ka_mult_seq: a 163/41 instance watched every cycle by a
// queue-based reference model, plus 8/3 and 8/8 instances driven in lockstep.
// Honours GF2_MULT_REDUCE_EN the same way the design does.
module tb_gf2_ka_mult_seq;

    localparam int W    = 163;
    localparam int D    = 41;
    localparam int NDIG = 4;
`ifdef GF2_MULT_REDUCE_EN
    localparam int LAT   = NDIG + 1;
    localparam int LAT_3 = 4;
    localparam int LAT_8 = 2;
`else
    localparam int LAT   = NDIG;
    localparam int LAT_3 = 3;
    localparam int LAT_8 = 1;
`endif

    logic           clk;
    logic           rst_n;
    logic           in_valid;
    logic           in_ready;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic           out_valid;
    logic           out_ready;
    logic [2*W-2:0] y;

    logic           sInValid;
    logic           sOutReady;
    logic [7:0]     sa;
    logic [7:0]     sb;
    logic           inReady3, inReady8;
    logic           outValid3, outValid8;
    logic [14:0]    y3, y8;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    bit monOn  = 0;

    logic [324:0] expQ[$];
    int           accQ[$];
    bit           expValid;

    gf2_ka_mult_seq #(.WIDTH(W), .DIGIT(D), .POLY(163'hC9)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready), .y(y)
    );

    gf2_ka_mult_seq #(.WIDTH(8), .DIGIT(3), .POLY(8'hC9)) dutS3 (
        .clk(clk), .rst_n(rst_n), .in_valid(sInValid), .in_ready(inReady3),
        .a(sa), .b(sb), .out_valid(outValid3), .out_ready(sOutReady), .y(y3)
    );

    gf2_ka_mult_seq #(.WIDTH(8), .DIGIT(8), .POLY(8'hC9)) dutS8 (
        .clk(clk), .rst_n(rst_n), .in_valid(sInValid), .in_ready(inReady8),
        .a(sa), .b(sb), .out_valid(outValid8), .out_ready(sOutReady), .y(y8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Reference product for w-bit operands. Unreduced: textbook coefficient
    // convolution. Reduced: shift-and-add with a running a*x^j mod f.
    function automatic logic [324:0] refMul(input logic [162:0] x, input logic [162:0] z,
                                            input int w, input logic [162:0] poly);
        logic [324:0] r;
`ifdef GF2_MULT_REDUCE_EN
        logic [163:0] t;
        r = '0;
        t = {1'b0, x};
        for (int j = 0; j < w; j++) begin
            if (z[j]) r[162:0] = r[162:0] ^ t[162:0];
            t = t << 1;
            if (t[w]) begin
                t[w] = 1'b0;
                t[162:0] = t[162:0] ^ poly;
            end
        end
`else
        r = '0;
        for (int i = 0; i < w; i++)
            for (int j = 0; j < w; j++)
                r[i+j] = r[i+j] ^ (x[i] & z[j]);
`endif
        return r;
    endfunction

    function automatic logic [162:0] rand163();
        logic [191:0] t;
        t = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        return t[162:0];
    endfunction

    task automatic checkVal(input string name, input logic [324:0] got, input logic [324:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Compare process for the wide instance: in_ready, out_valid and y are
    // predicted from the queue of accepted operations every cycle.
    always @(negedge clk) begin
        if (monOn) begin
            expValid = 1'b0;
            if (expQ.size() > 0) expValid = ((cyc - accQ[0]) >= LAT);
            checkVal("mon in_ready", {324'b0, in_ready}, {324'b0, expQ.size() == 0});
            checkVal("mon out_valid", {324'b0, out_valid}, {324'b0, expValid});
            if (out_valid && expQ.size() > 0) checkVal("mon y", y, expQ[0]);
            if (!rst_n) begin
                expQ.delete();
                accQ.delete();
            end else begin
                if (out_valid && out_ready && expQ.size() > 0) begin
                    void'(expQ.pop_front());
                    void'(accQ.pop_front());
                end
                if (in_valid && in_ready) begin
                    expQ.push_back(refMul(a, b, W, 163'hC9));
                    accQ.push_back(cyc + 1);
                end
            end
        end
    end

    // Present operands on the wide instance and return just after the
    // accepting edge; in_valid is left high for back-to-back use.
    task automatic applyStimulus(input logic [162:0] x, input logic [162:0] z);
        int n;
        n = 0;
        a = x;
        b = z;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("[TB] FAIL accept timeout: in_ready got 0 expected 1");
        end
        @(posedge clk);
        #1;
    endtask

    // Wait for the wide instance's result; lat counts edges since accept.
    task automatic waitResult(output logic [324:0] got, output int lat);
        int n;
        int start;
        n = 0;
        start = cyc;
        @(negedge clk);
        while (!out_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!out_valid) begin
            checks++;
            errors++;
            $display("[TB] FAIL result timeout: out_valid got 0 expected 1");
        end
        got = y;
        lat = cyc - start;
        @(posedge clk);
        #1;
    endtask

    // One operation through both small instances with their own model check.
    task automatic checkOutput(input logic [7:0] x, input logic [7:0] z);
        int start;
        bit seen3;
        bit seen8;
        logic [324:0] e;
        seen3 = 0;
        seen8 = 0;
        e = refMul({155'b0, x}, {155'b0, z}, 8, 163'hC9);
        checkVal("small ready", {323'b0, inReady3, inReady8}, 325'd3);
        sa = x;
        sb = z;
        sInValid = 1'b1;
        @(posedge clk);
        #1;
        sInValid = 1'b0;
        start = cyc;
        for (int n = 0; n < 20 && !(seen3 && seen8); n++) begin
            @(negedge clk);
            if (outValid3 && !seen3) begin
                seen3 = 1;
                checkVal("s3 y", {310'b0, y3}, e);
                checkVal("s3 latency", 325'(cyc - start), 325'(LAT_3));
            end
            if (outValid8 && !seen8) begin
                seen8 = 1;
                checkVal("s8 y", {310'b0, y8}, e);
                checkVal("s8 latency", 325'(cyc - start), 325'(LAT_8));
            end
        end
        if (!(seen3 && seen8)) begin
            checks++;
            errors++;
            $display("[TB] FAIL small timeout: seen %0d%0d expected 11", seen3, seen8);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [324:0] got;
        logic [324:0] e;
        logic [162:0] top;
        logic [162:0] held;
        int lat;
        int accEdge[4];
        int n;

        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        a = '0;
        b = '0;
        sInValid = 1'b0;
        sOutReady = 1'b1;
        sa = '0;
        sb = '0;
        repeat (2) @(posedge clk);
        #1;
        monOn = 1;
        checkVal("reset y", y, '0);
        checkVal("reset out_valid", {324'b0, out_valid}, '0);
        checkVal("reset in_ready", {324'b0, in_ready}, 325'd1);
        rst_n = 1'b1;

        // Pin the reference model on hand-worked products.
        checkVal("model 3x3", refMul(163'd3, 163'd3, 163, 163'hC9), 325'd5);
        top = '0;
        top[162] = 1'b1;
`ifdef GF2_MULT_REDUCE_EN
        checkVal("model x162*x", refMul(top, 163'd2, 163, 163'hC9), 325'hC9);
`else
        e = '0;
        e[324] = 1'b1;
        checkVal("model x162*x162", refMul(top, top, 163, 163'hC9), e);
        checkVal("model ff*ff", refMul(163'hFF, 163'hFF, 8, 163'hC9), 325'h5555);
`endif

        applyStimulus(163'd3, 163'd3);
        in_valid = 1'b0;
        waitResult(got, lat);
        checkVal("3x3 y", got, 325'd5);
        checkVal("3x3 latency", 325'(lat), 325'(LAT));

`ifdef GF2_MULT_REDUCE_EN
        applyStimulus(top, 163'd2);
        in_valid = 1'b0;
        waitResult(got, lat);
        checkVal("x162*x reduced", got, 325'hC9);
        checkVal("x162*x latency", 325'(lat), 325'd5);
`else
        applyStimulus(top, top);
        in_valid = 1'b0;
        waitResult(got, lat);
        e = '0;
        e[324] = 1'b1;
        checkVal("x162*x162", got, e);
`endif

        // Backpressure: result must hold while new operands are offered.
        out_ready = 1'b0;
        applyStimulus(rand163(), rand163());
        in_valid = 1'b0;
        waitResult(got, lat);
        for (int k = 0; k < 10; k++) begin
            in_valid = 1'b1;
            a = rand163();
            b = rand163();
            @(negedge clk);
            checkVal("bp y stable", y, got);
            checkVal("bp out_valid", {324'b0, out_valid}, 325'd1);
            checkVal("bp in_ready", {324'b0, in_ready}, '0);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        checkVal("bp release in_ready", {324'b0, in_ready}, 325'd1);
        checkVal("bp release out_valid", {324'b0, out_valid}, '0);
        @(posedge clk);
        #1;

        // Reset in the middle of MUL.
        applyStimulus(rand163(), rand163());
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        checkVal("midreset out_valid", {324'b0, out_valid}, '0);
        checkVal("midreset y", y, '0);
        checkVal("midreset in_ready", {324'b0, in_ready}, 325'd1);
        repeat (6) @(posedge clk);
        #1;
        held = '0;
        held[100] = 1'b1;
        applyStimulus(163'd1, held);
        in_valid = 1'b0;
        waitResult(got, lat);
        e = '0;
        e[100] = 1'b1;
        checkVal("after reset x^100", got, e);

        // Back-to-back: MUL for LAT cycles, one DONE cycle, one IDLE cycle,
        // so accepts are LAT+2 edges apart.
        for (int k = 0; k < 4; k++) begin
            applyStimulus(rand163(), rand163());
            accEdge[k] = cyc;
        end
        in_valid = 1'b0;
        for (int k = 1; k < 4; k++)
            checkVal("b2b spacing", 325'(accEdge[k] - accEdge[k-1]), 325'(LAT + 2));

        for (int k = 0; k < 1000; k++) applyStimulus(rand163(), rand163());
        in_valid = 1'b0;
        n = 0;
        while (expQ.size() > 0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        #1;
        checkVal("drain", 325'(expQ.size()), '0);

        // Narrow configurations: corner vectors, then random.
        checkOutput(8'hFF, 8'hFF);
        checkOutput(8'h00, 8'hA5);
        checkOutput(8'h80, 8'h80);
        checkOutput(8'h01, 8'h01);
        for (int k = 0; k < 1000; k++) checkOutput(8'($urandom), 8'($urandom));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
